mem_bus_arbiter: RTL and testbench
==================================

# mem_bus_arbiter

Round-robin arbiter sharing the single memory/L2 port between the per-core cache controllers of the multicore RISC-V system. Each requester holds a one-word read or write request; the arbiter grants one at a time, owns the memory handshake for the granted transaction, returns read data and a completion pulse, and rotates priority so no core starves. A watchdog aborts transactions the memory never acknowledges.

## Interface
- NUM_REQ, 2: number of requesting cache controllers (2..8)
- ADDR_WIDTH, 32: address width
- DATA_WIDTH, 32: data width
- TIMEOUT, 255: maximum wait cycles for mem_ready before abort (1..65535)

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- req  in  NUM_REQ  per-requester request level
- req_we  in  NUM_REQ  per-requester write enable (1 = write)
- req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- req_wdata  in  NUM_REQ*DATA_WIDTH  packed write data, same packing
- gnt  out  NUM_REQ  one-hot grant, held for whole transaction
- gnt_id  out  $clog2(NUM_REQ)  index of current or last winner
- done  out  NUM_REQ  one-cycle completion pulse to winner
- err  out  1  valid with done; 1 = timed out
- rdata  out  DATA_WIDTH  read data, valid with done
- busy  out  1  high in any state except IDLE
- mem_req  out  1  memory request level
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_WIDTH  memory address
- mem_wdata  out  DATA_WIDTH  memory write data
- mem_ready  in  1  memory acknowledge; read data valid same cycle
- mem_rdata  in  DATA_WIDTH  memory read data

## Operation
- States: IDLE, MEM, RESP.
- IDLE: if any req bit set, winner = first set bit at or above ptr, wrapping modulo NUM_REQ. At the next edge: gnt[winner] <= 1, gnt_id <= winner, latch winner's we/addr/wdata into mem_we/mem_addr/mem_wdata, mem_req <= 1, clear watchdog, go to MEM. No request: stay.
- MEM: mem_req held, mem_* stable. Watchdog increments each cycle. If mem_ready = 1: rdata <= mem_rdata (write: rdata <= 0), err <= 0. Else if watchdog == TIMEOUT-1: rdata <= 0, err <= 1. On either: done[winner] <= 1, gnt <= 0, mem_req <= 0, ptr <= (winner+1) mod NUM_REQ, go to RESP.
- RESP: done, rdata and err valid for exactly this cycle; req ignored. Next edge: done <= 0, err <= 0, go to IDLE. rdata holds until the next completion.
- Requester protocol: hold req, we, addr and wdata stable from assertion until done. Drop req in the done cycle unless a new request is intended. A req still high in the first IDLE cycle is a new request.
- Request withdrawn while granted: the transaction still completes and done still pulses, because memory transactions are not abortable.
- A mem_ready outside MEM is ignored.
- mem_ready and timeout in the same cycle: mem_ready wins, err = 0.
- Reset (asserted at any time, including mid-transaction): immediately state IDLE, ptr = 0, gnt = 0, gnt_id = 0, done = 0, err = 0, rdata = 0, busy = 0, mem_req = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0. An in-flight memory access is abandoned.

## Timing
- Request seen in IDLE at edge n: gnt and mem_req high from cycle n+1.
- mem_ready sampled high at edge k: done, rdata and err valid in cycle k+1, gnt low from cycle k+1, IDLE in cycle k+2, earliest next grant in cycle k+3.
- Minimum transaction with mem_ready returned in the first MEM cycle: done 2 cycles after request, 3-cycle grant-to-grant spacing.
- Timeout: done with err = 1 exactly TIMEOUT cycles after mem_req rises.
- All outputs are registered. No combinational path from inputs to outputs.

## Test plan
- Single read: req[0] = 1, addr 0x100, mem_ready 2 cycles after mem_req with mem_rdata 0xDEADBEEF -> gnt[0] 1 cycle after req; mem_addr = 0x100, mem_we = 0; done[0] with rdata 0xDEADBEEF and err 0.
- Write: req[1] = 1, we = 1, addr 0x200, wdata 0x12345678 -> mem_we = 1, mem_wdata = 0x12345678; done[1] with rdata 0.
- Contention (NUM_REQ = 2): both req held continuously, each dropped only in its done cycle then re-raised -> grants alternate 0,1,0,1 and gnt_id toggles. Repeat with NUM_REQ = 4, all requesting -> order 0,1,2,3,0.
- Timeout: TIMEOUT = 8, mem_ready never asserted -> done[0] with err = 1 exactly 8 cycles after mem_req rose; mem_req low next cycle; the next request is served normally.
- Reset mid-MEM: assert reset 3 cycles into MEM -> all outputs 0 asynchronously. After release, req[1] and req[0] both high -> req[0] granted first (ptr = 0).
- Edge cases: mem_ready pulsed in IDLE is ignored. mem_ready coinciding with the timeout cycle gives err = 0. Dropping req while granted still yields done.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter that shares one memory port among NUM_REQ cache controllers,
// with a watchdog that aborts transactions memory never acknowledges.
module mem_bus_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255,
  localparam int IDW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_REQ-1:0]               req,
  input  logic [NUM_REQ-1:0]               req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
  output logic [NUM_REQ-1:0]               gnt,
  output logic [IDW-1:0]                   gnt_id,
  output logic [NUM_REQ-1:0]               done,
  output logic                             err,
  output logic [DATA_WIDTH-1:0]            rdata,
  output logic                             busy,
  output logic                             mem_req,
  output logic                             mem_we,
  output logic [ADDR_WIDTH-1:0]            mem_addr,
  output logic [DATA_WIDTH-1:0]            mem_wdata,
  input  logic                             mem_ready,
  input  logic [DATA_WIDTH-1:0]            mem_rdata,
  output logic [1:0]                       state_dbg
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MEM  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [IDW-1:0] LAST_ID = IDW'(NUM_REQ - 1);
  localparam logic [15:0]    WD_LAST = 16'(TIMEOUT - 1);

  logic [1:0]     state;
  logic [IDW-1:0] ptr;
  logic [15:0]    wd;
  logic           found;
  logic [IDW-1:0] winner;
  logic [IDW-1:0] idx;

  // First requester at or above ptr, wrapping.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = IDW'((int'(ptr) + i) % NUM_REQ);
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  // Memory handshake: mem_req is a level, held with mem_we/mem_addr/mem_wdata stable,
  // until mem_ready is sampled high in MEM; that edge completes the transfer and
  // mem_rdata is taken in the same cycle. mem_ready outside MEM has no effect.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      ptr       <= '0;
      wd        <= '0;
      gnt       <= '0;
      gnt_id    <= '0;
      done      <= '0;
      err       <= 1'b0;
      rdata     <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (found) begin
            state     <= S_MEM;
            gnt       <= NUM_REQ'(1) << winner;
            gnt_id    <= winner;
            mem_req   <= 1'b1;
            mem_we    <= req_we[winner];
            mem_addr  <= req_addr[int'(winner)*ADDR_WIDTH +: ADDR_WIDTH];
            mem_wdata <= req_wdata[int'(winner)*DATA_WIDTH +: DATA_WIDTH];
            wd        <= '0;
          end
        end
        S_MEM: begin
          wd <= wd + 16'd1;
          // An acknowledge in the watchdog's final cycle still counts as success.
          if (mem_ready || wd == WD_LAST) begin
            err     <= !mem_ready;
            rdata   <= (mem_ready && !mem_we) ? mem_rdata : '0;
            done    <= gnt;
            gnt     <= '0;
            mem_req <= 1'b0;
            ptr     <= (gnt_id == LAST_ID) ? '0 : gnt_id + 1'b1;
            state   <= S_RESP;
          end
        end
        S_RESP: begin
          done  <= '0;
          err   <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy      = (state != S_IDLE);
  assign state_dbg = state;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Randomized bench for mem_bus_arbiter: a transaction-level round-robin model
// predicts winner, timing, rdata and err for each grant.
module tb_mem_bus_arbiter;

  localparam int N   = 4;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TO  = 8;
  localparam int IDW = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req;
  logic [N-1:0]    req_we;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N-1:0]    gnt;
  logic [IDW-1:0]  gnt_id;
  logic [N-1:0]    done;
  logic            err;
  logic [DW-1:0]   rdata;
  logic            busy;
  logic            mem_req;
  logic            mem_we;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic            mem_ready;
  logic [DW-1:0]   mem_rdata;
  logic [1:0]      state_dbg;

  mem_bus_arbiter #(
    .NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .gnt(gnt), .gnt_id(gnt_id), .done(done), .err(err),
    .rdata(rdata), .busy(busy), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  int n_checks = 0;
  int n_pass   = 0;
  int rr_ptr   = 0;
  logic [IDW+DW:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int pick(input logic [N-1:0] m, input int p);
    for (int i = 0; i < N; i++)
      if (m[(p + i) % N]) return (p + i) % N;
    return -1;
  endfunction

  // driver tasks
  task automatic set_req(input int i, input logic we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
    req[i]                = 1'b1;
    req_we[i]             = we;
    req_addr[i*AW +: AW]  = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  task automatic set_rand_req(input int i);
    set_req(i, 1'($urandom_range(0, 1)), $urandom, $urandom);
  endtask

  task automatic check_reset_outputs();
    check("rst_gnt",       64'(gnt),       64'(0));
    check("rst_gnt_id",    64'(gnt_id),    64'(0));
    check("rst_done",      64'(done),      64'(0));
    check("rst_err",       64'(err),       64'(0));
    check("rst_rdata",     64'(rdata),     64'(0));
    check("rst_busy",      64'(busy),      64'(0));
    check("rst_mem_req",   64'(mem_req),   64'(0));
    check("rst_mem_we",    64'(mem_we),    64'(0));
    check("rst_mem_addr",  64'(mem_addr),  64'(0));
    check("rst_mem_wdata", 64'(mem_wdata), 64'(0));
  endtask

  // Called in an IDLE cycle with at least one req set. lat = MEM cycles before
  // mem_ready (>= TO means never acknowledged).
  task automatic serve_one(input int lat, input logic [DW-1:0] rd, input bit withdraw,
                           input logic [N-1:0] reraise);
    int              w;
    logic [N-1:0]    oh;
    logic            e_we;
    logic [AW-1:0]   e_addr;
    logic [DW-1:0]   e_wdata;
    logic            e_err;
    logic [IDW+DW:0] e;
    w = pick(req, rr_ptr);
    if (w < 0) return;
    oh      = N'(1) << w;
    e_we    = req_we[w];
    e_addr  = req_addr[w*AW +: AW];
    e_wdata = req_wdata[w*DW +: DW];
    e_err   = (lat > TO - 1);
    exp_q.push_back({IDW'(w), e_err, (e_err || e_we) ? {DW{1'b0}} : rd});

    step();
    check("gnt",       64'(gnt),       64'(oh));
    check("gnt_id",    64'(gnt_id),    64'(w));
    check("mem_req",   64'(mem_req),   64'(1));
    check("mem_we",    64'(mem_we),    64'(e_we));
    check("mem_addr",  64'(mem_addr),  64'(e_addr));
    check("mem_wdata", 64'(mem_wdata), 64'(e_wdata));
    check("busy_mem",  64'(busy),      64'(1));

    for (int c = 0; c < TO; c++) begin
      mem_ready = (c == lat);
      mem_rdata = (c == lat) ? rd : $urandom;
      if (withdraw && c == 0) req[w] = 1'b0;
      step();
      if (c == lat || c == TO - 1) break;
      check("gnt_held",   64'(gnt),  64'(oh));
      check("done_early", 64'(done), 64'(0));
    end

    e = exp_q.pop_front();
    check("done",        64'(done),    64'(N'(1) << e[IDW+DW -: IDW]));
    check("err",         64'(err),     64'(e[DW]));
    check("rdata",       64'(rdata),   64'(e[DW-1:0]));
    check("gnt_off",     64'(gnt),     64'(0));
    check("mem_req_off", 64'(mem_req), 64'(0));
    rr_ptr = (w + 1) % N;
    req[w] = 1'b0;
    mem_ready = 1'($urandom_range(0, 1));

    step();
    check("done_clr",   64'(done),  64'(0));
    check("err_clr",    64'(err),   64'(0));
    check("busy_idle",  64'(busy),  64'(0));
    check("rdata_hold", 64'(rdata), 64'(e[DW-1:0]));
    mem_ready = 1'($urandom_range(0, 1));
    if (reraise[w]) set_rand_req(w);
  endtask

  task automatic drain();
    for (int k = 0; k < N && req != '0; k++)
      serve_one($urandom_range(0, 3), $urandom, 1'b0, '0);
  endtask

  initial begin
    int lat;
    reset = 1'b0; req = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    mem_ready = 1'b0; mem_rdata = '0;
    step(); step();
    check_reset_outputs();
    reset = 1'b1;
    step();

    // single read, then write
    set_req(0, 1'b0, 32'h100, 32'h0);
    serve_one(2, 32'hDEADBEEF, 1'b0, '0);
    set_req(1, 1'b1, 32'h200, 32'h12345678);
    serve_one(0, 32'hCAFEF00D, 1'b0, '0);

    // timeout, then normal service, then acknowledge in the timeout cycle
    set_req(0, 1'b0, 32'h300, 32'h0);
    serve_one(1000, 32'h11111111, 1'b0, '0);
    set_req(2, 1'b0, 32'h304, 32'h0);
    serve_one(1, 32'h22222222, 1'b0, '0);
    set_req(3, 1'b0, 32'h308, 32'h0);
    serve_one(TO - 1, 32'h33333333, 1'b0, '0);

    // withdrawn while granted still completes
    set_req(1, 1'b0, 32'h30C, 32'h0);
    serve_one(2, 32'h44444444, 1'b1, '0);

    // two-way contention, then all four
    set_rand_req(0); set_rand_req(1);
    for (int k = 0; k < 4; k++) serve_one(0, $urandom, 1'b0, 4'b0011);
    drain();
    for (int i = 0; i < N; i++) set_rand_req(i);
    for (int k = 0; k < 5; k++) serve_one(1, $urandom, 1'b0, 4'b1111);
    drain();

    // reset mid-MEM after leaving ptr non-zero
    set_req(0, 1'b0, 32'h400, 32'h0);
    serve_one(0, 32'hA5A5A5A5, 1'b0, '0);
    set_req(0, 1'b1, 32'h500, 32'h55AA55AA);
    mem_ready = 1'b0;
    step();
    step(); step(); step();
    #2;
    reset = 1'b0;
    #1;
    check_reset_outputs();
    req = '0;
    set_rand_req(1); set_rand_req(0);
    step(); step();
    reset = 1'b1;
    rr_ptr = 0;
    serve_one(0, $urandom, 1'b0, '0);
    serve_one(0, $urandom, 1'b0, '0);

    // randomized traffic
    for (int it = 0; it < 40; it++) begin
      for (int i = 0; i < N; i++)
        if (!req[i] && $urandom_range(0, 2) == 0) set_rand_req(i);
      if (req == '0) set_rand_req($urandom_range(0, N - 1));
      case ($urandom_range(0, 5))
        4:       lat = TO - 1;
        5:       lat = 1000;
        default: lat = $urandom_range(0, 3);
      endcase
      serve_one(lat, $urandom, ($urandom_range(0, 5) == 0), N'($urandom));
    end
    drain();

    check("scoreboard_empty", 64'(exp_q.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
